// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM encoding
// and helpers for the framed RX/TX blocks.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH,
    ST_WAITHI
  } rx_state_t;

  // centre of a bit cell; votes use MID-1..MID+1
  function automatic int vote_mid(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// uart_rx_framed_if: received-word stream with
// error tags and a valid/ready handshake.
interface uart_rx_framed_if #(
  parameter int W = 8
);

  logic [W-1:0] data;
  logic         parity_err;
  logic         frame_err;
  logic         valid;
  logic         ready;

  modport master (
    output data, parity_err, frame_err, valid,
    input  ready
  );

  modport slave (
    input  data, parity_err, frame_err, valid,
    output ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO holding
// {frame_err, parity_err, data} words.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   wr_en,
  input  logic [DATA_BITS+1:0]   wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  uart_rx_framed_if.master       rd
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = DATA_BITS + 2;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] head;
  logic         push;
  logic         pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  assign pop  = rd.valid && rd.ready;
  assign push = wr_en && (!full || pop);

  // empty FIFO shows zeros, not stale storage
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign rd.valid      = !empty;
  assign rd.data       = head[DATA_BITS-1:0];
  assign rd.parity_err = head[DATA_BITS];
  assign rd.frame_err  = head[DATA_BITS+1];

  // read/write pointers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // word storage
  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: voting UART receiver with
// parity/framing tags and an output FIFO.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iRxSerial,
  output logic [DATA_BITS-1:0]        oData,
  output logic                        oParityErr,
  output logic                        oFrameErr,
  output logic                        oValid,
  input  logic                        iReady,
  output logic                        oOverrun,
  input  logic                        iClrOverrun,
  output logic                        oBusy,
  output logic [$clog2(FIFO_DEPTH):0] oLevel
);

  if (BAUD_RATE <= 0 || CLK_FREQ < BAUD_RATE) begin : g_bad_rate
    $error("bad CLK_FREQ/BAUD_RATE");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0..2");
  end
  if (FIFO_DEPTH < 2
      || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_dep
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  localparam int MID = vote_mid(CLKS_PER_BIT);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] V0   = CW'(MID - 1);
  localparam logic [CW-1:0] V1   = CW'(MID);
  localparam logic [CW-1:0] V2   = CW'(MID + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DB_L = BW'(DATA_BITS - 1);
  localparam logic          SB_L = (STOP_BITS == 2);

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_n;
  logic                 stop_n;
  logic                 s1;
  logic                 s2;
  logic                 v0;
  logic                 v1;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 busy;
  logic                 ovr;
  logic                 rx;
  logic                 vote;
  logic                 par_x;
  logic                 wr_en;
  logic                 full;
  logic                 empty;
  logic                 pop;

  uart_rx_framed_if #(.W(DATA_BITS)) sif ();

  assign rx    = s2;
  assign vote  = (v0 & v1) | (v0 & rx) | (v1 & rx);
  assign par_x = (^shreg) ^ vote;
  assign wr_en = (state == ST_PUSH);
  assign pop   = sif.valid && sif.ready;

  // two-flop synchroniser, idles high
  always_ff @(posedge iClk) begin
    if (iRst) {s2, s1} <= 2'b11;
    else      {s2, s1} <= {s1, iRxSerial};
  end

  // frame FSM with registered busy and word fields
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bit_n  <= '0;
      stop_n <= 1'b0;
      v0     <= 1'b1;
      v1     <= 1'b1;
      shreg  <= '0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (cnt == V0) v0 <= rx;
      if (cnt == V1) v1 <= rx;
      unique case (state)
        ST_IDLE: begin
          if (!rx) begin
            state  <= ST_START;
            cnt    <= '0;
            bit_n  <= '0;
            stop_n <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            busy   <= 1'b1;
          end
        end
        ST_START: begin
          cnt <= cnt + 1'b1;
          if (cnt == V2 && vote) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state <= ST_DATA;
            cnt   <= '0;
          end
        end
        ST_DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == V2) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_n == DB_L)
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              bit_n <= bit_n + 1'b1;
          end
        end
        ST_PARITY: begin
          cnt <= cnt + 1'b1;
          if (cnt == V2)
            perr <= (PARITY == PAR_ODD) ? ~par_x : par_x;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          cnt <= cnt + 1'b1;
          if (cnt == V2) begin
            if (!vote) ferr <= 1'b1;
            if (stop_n == SB_L) state <= ST_PUSH;
          end
          if (cnt == LAST) begin
            cnt    <= '0;
            stop_n <= 1'b1;
          end
        end
        ST_PUSH: begin
          if (ferr) begin
            state <= ST_WAITHI;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_WAITHI: begin
          if (rx) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // sticky overrun; a fresh drop wins over a clear
  always_ff @(posedge iClk) begin
    if (iRst)                        ovr <= 1'b0;
    else if (wr_en && full && !pop)  ovr <= 1'b1;
    else if (iClrOverrun)            ovr <= 1'b0;
  end

  uart_rx_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .iClk    (iClk),
    .iRst    (iRst),
    .wr_en   (wr_en),
    .wr_data ({ferr, perr, shreg}),
    .full    (full),
    .empty   (empty),
    .level   (oLevel),
    .rd      (sif.master)
  );

  assign sif.ready  = iReady;
  assign oData      = sif.data;
  assign oParityErr = sif.parity_err;
  assign oFrameErr  = sif.frame_err;
  assign oValid     = !empty;
  assign oOverrun   = ovr;
  assign oBusy      = busy;

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: four receiver configurations
// checked by a scoreboard against a frame model.
`timescale 1ns/1ps
module tb_uart_rx_framed;

  localparam int CPB = 16;
  localparam int NU  = 4;

  function automatic int cfg_db(input int g);
    return (g == 2) ? 7 : (g == 3) ? 9 : 8;
  endfunction
  function automatic int cfg_par(input int g);
    return (g == 1) ? 2 : (g == 3) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int g);
    return (g == 2) ? 2 : 1;
  endfunction
  function automatic int cfg_dep(input int g);
    return (g == 0) ? 4 : 16;
  endfunction

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [8:0] d;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx   [NU];
  logic       rdy  [NU];
  logic       clr  [NU];
  logic [8:0] data [NU];
  logic       pe   [NU];
  logic       fe   [NU];
  logic       vld  [NU];
  logic       ovr  [NU];
  logic       busy [NU];
  logic [4:0] lvl  [NU];
  word_t      expq [NU][$];
  int         exp_ovr [NU];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : u
    localparam int DB  = cfg_db(g);
    localparam int DEP = cfg_dep(g);
    localparam int LW  = $clog2(DEP) + 1;

    logic [LW-1:0] lv;

    uart_rx_framed_if #(.W(DB)) mon ();

    uart_rx_framed #(
      .CLK_FREQ   (1_600_000),
      .BAUD_RATE  (100_000),
      .DATA_BITS  (DB),
      .PARITY     (cfg_par(g)),
      .STOP_BITS  (cfg_sb(g)),
      .FIFO_DEPTH (DEP)
    ) dut (
      .iClk        (clk),
      .iRst        (rst),
      .iRxSerial   (rx[g]),
      .oData       (mon.data),
      .oParityErr  (mon.parity_err),
      .oFrameErr   (mon.frame_err),
      .oValid      (mon.valid),
      .iReady      (mon.ready),
      .oOverrun    (ovr[g]),
      .iClrOverrun (clr[g]),
      .oBusy       (busy[g]),
      .oLevel      (lv)
    );

    assign mon.ready = rdy[g];
    assign data[g]   = 9'(mon.data);
    assign pe[g]     = mon.parity_err;
    assign fe[g]     = mon.frame_err;
    assign vld[g]    = mon.valid;
    assign lvl[g]    = 5'(lv);

    // pop and compare every accepted word
    always @(negedge clk) begin
      word_t got;
      word_t e;
      if (!rst && mon.valid && mon.ready) begin
        got = {mon.frame_err, mon.parity_err, 9'(mon.data)};
        tests++;
        if (expq[g].size() == 0) begin
          fails++;
          $display("FAIL u%0d extra_word got=%h none expected",
                   g, got);
        end else begin
          e = expq[g].pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL u%0d word got=%h exp=%h", g, got, e);
          end
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got,
                     input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive_bit(input int g, input logic b);
    rx[g] = b;
    hold(CPB);
  endtask

  // model: expected word follows from the bits on the line
  task automatic send_frame(input int g, input logic [8:0] dat,
                            input bit bad_par);
    int n;
    int p;
    int ones;
    logic pb;
    logic pe_m;
    word_t e;
    n    = cfg_db(g);
    p    = cfg_par(g);
    ones = 0;
    drive_bit(g, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive_bit(g, dat[i]);
      ones += int'(dat[i]);
    end
    pb = 1'b0;
    if (p == 1) pb = (ones % 2 == 0);
    if (p == 2) pb = (ones % 2 == 1);
    pb = pb ^ bad_par;
    if (p != 0) drive_bit(g, pb);
    ones += int'(pb);
    pe_m = (p == 1 && ones % 2 == 0) || (p == 2 && ones % 2 == 1);
    e = {1'b0, pe_m, dat & 9'((1 << n) - 1)};
    if (!rdy[g] && expq[g].size() >= cfg_dep(g))
      exp_ovr[g] = 1;
    else
      expq[g].push_back(e);
    for (int s = 0; s < cfg_sb(g); s++) drive_bit(g, 1'b1);
  endtask

  task automatic wait_idle(input int g, input string name);
    int t;
    t = 0;
    while (busy[g] && t < 400) begin
      hold(1);
      t++;
    end
    chk(name, int'(busy[g]), 0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (t < 4000 && (expq[0].size() + expq[1].size()
           + expq[2].size() + expq[3].size()) != 0) begin
      hold(1);
      t++;
    end
    for (int g = 0; g < NU; g++)
      chk($sformatf("drain_u%0d", g), expq[g].size(), 0);
  endtask

  task automatic rand_frames(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      send_frame(g, 9'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) drive_bit(g, 1'b1);
    end
  endtask

  initial begin
    int saw;
    for (int g = 0; g < NU; g++) begin
      rx[g]      = 1'b1;
      rdy[g]     = 1'b1;
      clr[g]     = 1'b0;
      exp_ovr[g] = 0;
    end
    rst = 1'b1;
    hold(4);
    for (int g = 0; g < NU; g++)
      chk($sformatf("reset_u%0d", g),
          int'({vld[g], ovr[g], busy[g], pe[g], fe[g],
                lvl[g], data[g]}), 0);
    rst = 1'b0;
    hold(4);

    // basic 8N1 word
    send_frame(0, 9'hA5, 1'b0);
    wait_idle(0, "busy_after_a5");
    hold(4);
    chk("lvl_after_a5", int'(lvl[0]), 0);

    // even parity, bad then good parity bit
    send_frame(1, 9'h03, 1'b1);
    send_frame(1, 9'h03, 1'b0);
    wait_idle(1, "busy_after_par");

    // start-bit glitch
    rx[0] = 1'b0;
    hold(4);
    rx[0] = 1'b1;
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy[0]) saw = 1;
      hold(1);
    end
    chk("glitch_busy_pulse", saw, 1);
    chk("glitch_busy_end", int'(busy[0]), 0);
    chk("glitch_lvl", int'(lvl[0]), 0);

    // break then a normal word
    expq[0].push_back({1'b1, 1'b0, 9'h000});
    rx[0] = 1'b0;
    hold(30 * CPB);
    rx[0] = 1'b1;
    hold(2 * CPB);
    send_frame(0, 9'h5A, 1'b0);
    wait_idle(0, "busy_after_break");
    wait_drain();

    // overrun with depth 4
    rdy[0] = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(0, 9'(v * 'h11), 1'b0);
      drive_bit(0, 1'b1);
    end
    chk("ovr_level", int'(lvl[0]), 4);
    chk("ovr_flag", int'(ovr[0]), exp_ovr[0]);
    chk("ovr_head", int'(data[0]), 'h11);
    hold(7);
    chk("ovr_head_stable", int'(data[0]), 'h11);
    rdy[0] = 1'b1;
    hold(10);
    chk("ovr_drained", int'(lvl[0]), 0);
    chk("ovr_sticky", int'(ovr[0]), 1);
    clr[0] = 1'b1;
    exp_ovr[0] = 0;
    hold(1);
    clr[0] = 1'b0;
    chk("ovr_cleared", int'(ovr[0]), 0);
    wait_drain();

    // reset during data bit 3 of 0xFF
    drive_bit(0, 1'b0);
    rx[0] = 1'b1;
    hold(3 * CPB + CPB / 2);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(2 * CPB);
    chk("rst_mid_busy", int'(busy[0]), 0);
    chk("rst_mid_lvl", int'(lvl[0]), 0);
    send_frame(0, 9'h3C, 1'b0);
    wait_idle(0, "busy_after_3c");

    // 7-bit, two stop bits, back to back
    for (int i = 0; i < 3; i++) send_frame(2, 9'h07F, 1'b0);
    wait_idle(2, "busy_after_7f");
    wait_drain();

    // randomized traffic on all configurations
    fork
      rand_frames(0, 10);
      rand_frames(1, 14);
      rand_frames(2, 10);
      rand_frames(3, 14);
    join
    wait_drain();
    for (int g = 0; g < NU; g++)
      chk($sformatf("ovr_end_u%0d", g), int'(ovr[g]), exp_ovr[g]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver: configurable data width, parity, stop bits, per-bit 3-sample majority voting, start-bit glitch rejection and an output FIFO with valid/ready handshake. Sits between the board RX pin and the command/packet layer. Received words are tagged with parity and framing error flags, and overflow is reported instead of silently overwriting.

## Interface
- CLK_FREQ, 125_000_000: system clock in Hz.
- BAUD_RATE, 115_200: line rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE: clocks per bit; must be ≥ 8.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: output FIFO entries; power of 2, ≥ 2.

Ports:
- iClk  in  1  clock.
- iRst  in  1  synchronous reset, active-high.
- iRxSerial  in  1  asynchronous serial line; idles high.
- oData  out  DATA_BITS  head-of-FIFO data word; LSB is the first bit received.
- oParityErr  out  1  head-of-FIFO parity error tag; always 0 when PARITY = 0.
- oFrameErr  out  1  head-of-FIFO framing error tag.
- oValid  out  1  FIFO not empty.
- iReady  in  1  consumer accepts the head word.
- oOverrun  out  1  sticky flag: a frame was dropped.
- iClrOverrun  in  1  clears oOverrun.
- oBusy  out  1  FSM is not in IDLE.
- oLevel  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- iRxSerial passes through a 2-flop synchroniser. Both flops reset to 1.
- MID = CLKS_PER_BIT/2. Each bit is sampled at bit-counter values MID-1, MID and MID+1; the bit value is the 2-of-3 majority vote.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH, WAITHI.
- IDLE: synchronised line low → START, counter = 0.
- START: at the vote point, majority 1 → IDLE (glitch rejected, nothing pushed). At CLKS_PER_BIT-1 → DATA.
- DATA: shift DATA_BITS bits LSB-first. After the last bit → PARITY if PARITY ≠ 0, else STOP.
- PARITY: compute XOR of the data bits and the parity bit. Error if the XOR is 0 for odd parity or 1 for even parity.
- STOP: vote each stop bit; any stop bit voting 0 sets the frame error. At the vote point (MID+1) of the final stop bit → PUSH. The FSM does not wait for the end of the stop bit, so it can resynchronise on back-to-back frames.
- PUSH: writes {frameErr, parityErr, data} to the FIFO for exactly one cycle. Next state is IDLE, or WAITHI if frameErr = 1.
- WAITHI: wait for the synchronised line to go high, then → IDLE. A break condition yields exactly one entry.
- FIFO is show-ahead. A pop occurs when oValid && iReady.
- Push while full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the frame is dropped and oOverrun is set.
- iClrOverrun clears oOverrun. If a new overrun occurs in the same cycle as iClrOverrun, the flag stays set.

## Timing
- Reset values: every output is 0 and the FIFO is empty; FSM enters IDLE.
- Reset mid-frame aborts the frame; no partial word is pushed.
- oValid rises on the cycle after the PUSH cycle when the FIFO was empty.
- oData, oParityErr and oFrameErr are stable while oValid = 1 and iReady = 0.
- oLevel updates on the cycle after each push or pop. A simultaneous push and pop leaves oLevel unchanged.
- oBusy is 1 from the cycle START is entered until IDLE is re-entered.
- End-to-end latency, falling edge on the pin to the push: 2 (synchroniser) + CLKS_PER_BIT × (1 + DATA_BITS + parity bit + STOP_BITS − 1) + MID + 2 cycles.

## Structure
- Shared package uart_pkg:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - FSM state encoding;
  - function computing the vote point MID from CLKS_PER_BIT.
- Elaboration-time checks on DATA_BITS, STOP_BITS, CLKS_PER_BIT and FIFO_DEPTH.
- One sub-module, uart_rx_fifo: a synchronous show-ahead FIFO of width DATA_BITS+2, parametrised depth, exposing full, empty and level. The uart_pkg package can be reused by a future uart_tx_framed.

## Test plan
All scenarios use CLK_FREQ = 1_600_000 and BAUD_RATE = 100_000, so CLKS_PER_BIT = 16.
- 8N1, send 0xA5 with iReady = 1 → one word 0xA5, both error tags 0, oBusy returns to 0.
- PARITY = 2, send 0x03 with parity bit 1 → word 0x03, oParityErr = 1. Resend with parity bit 0 → oParityErr = 0.
- Hold the line low for 4 clocks, then high → no push, oLevel = 0, oBusy pulses then returns to 0.
- Break: line low for 30 bit times, then high, then send 0x5A → exactly two words, in order:
  - 0x00 with oFrameErr = 1;
  - 0x5A with oFrameErr = 0.
- FIFO_DEPTH = 4, iReady = 0, send 0x11, 0x22, 0x33, 0x44, 0x55 → oLevel = 4 and oOverrun = 1. Popping yields 0x11..0x44. iClrOverrun then clears oOverrun.
- Assert iRst during data bit 3 of 0xFF, then send 0x3C → only 0x3C is received.
- DATA_BITS = 7, STOP_BITS = 2, send 0x7F back-to-back ×3 → three words 0x7F, no error tags.
